// File: rtl/snake_pkg.sv
// snake_pkg: constants, encodings and helpers shared across the snake game blocks.
//   SCREEN_W/SCREEN_H : visible framebuffer size (160x120)
//   ADDR_W            : framebuffer address width (15 bits covers 0..19199)
//   BLACK/GREEN/WHITE : 3-bit colour constants
//   dir_e             : movement direction encodings
//   rd_state_e        : pixel_shadow_reader read FSM states
//   xy_to_addr        : pixel coordinate to linear framebuffer address
package snake_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned ADDR_W   = 15;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } rd_state_e;

    // y*160 + x using shifts only: y*128 + y*32 + x
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
        return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/shadow_ram_1r1w.sv
// shadow_ram_1r1w: simple dual-port RAM, one write port and one registered read port.
// No read-during-write guarantee; the parent forwards colliding writes itself.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address, sampled every edge
//   rdata : read data, valid one edge after raddr
module shadow_ram_1r1w #(
    parameter int unsigned DEPTH = 19200,
    parameter int unsigned AW    = 15,
    parameter int unsigned DW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage and read register; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pixel_shadow_reader.sv
// pixel_shadow_reader: shadow copy of the VGA pixel-write stream with a
// request/acknowledge read-back port for game logic (collision, food placement).
// Optional feature macro: PIXEL_SHADOW_CLEAR_EN -- when defined, a clear sweep
// zeroes the framebuffer after every reset and busy is high while it runs;
// otherwise the FSM resets to IDLE, busy is 0 and pixel data survives reset.
//   clk, reset             : clock, synchronous active-high reset
//   plot, x, y, colour     : pixel write stream (same wires as the VGA adapter)
//   rd_req, rd_x, rd_y     : read request, held until rd_ack
//   rd_ack                 : one-cycle pulse, rd_colour/rd_oob valid with it
//   rd_colour, rd_oob      : read-back colour, out-of-range flag
//   busy                   : clear sweep in progress
module pixel_shadow_reader
    import snake_pkg::*;
#(
    parameter int unsigned WIDTH    = 160,
    parameter int unsigned HEIGHT   = 120,
    parameter int unsigned COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                plot,
    input  logic [7:0]          x,
    input  logic [6:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                rd_req,
    input  logic [7:0]          rd_x,
    input  logic [6:0]          rd_y,
    output logic                rd_ack,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic                rd_oob,
    output logic                busy
);

    localparam int unsigned DEPTH = WIDTH * HEIGHT;

`ifdef PIXEL_SHADOW_CLEAR_EN
    localparam rd_state_e ST_RESET = ST_CLEAR;
`else
    localparam rd_state_e ST_RESET = ST_IDLE;
`endif

    rd_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  oob_q, oob_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_oob_q, rd_oob_d;
    logic                  fwd_hit_q, fwd_hit_d;
    logic [COLOUR_W-1:0]   fwd_colour_q, fwd_colour_d;
    logic                  busy_int;

    logic                  wr_en_c;
    logic [ADDR_W-1:0]     wr_addr_c;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_waddr;
    logic [COLOUR_W-1:0]   ram_wdata;
    logic [COLOUR_W-1:0]   ram_rdata;

`ifdef PIXEL_SHADOW_CLEAR_EN
    logic [ADDR_W-1:0]     sweep_q, sweep_d;
    logic                  busy_q, busy_d;
    assign busy_int = busy_q;
`else
    assign busy_int = 1'b0;
`endif

    // In-range user write, blocked while clearing
    assign wr_addr_c = xy_to_addr(x, y);
    assign wr_en_c   = plot && !busy_int && !reset
                       && (x < 8'(WIDTH)) && (y < 7'(HEIGHT));

    // The sweep owns the write port while busy
`ifdef PIXEL_SHADOW_CLEAR_EN
    assign ram_we    = busy_q | wr_en_c;
    assign ram_waddr = busy_q ? sweep_q : wr_addr_c;
    assign ram_wdata = busy_q ? '0 : colour;
`else
    assign ram_we    = wr_en_c;
    assign ram_waddr = wr_addr_c;
    assign ram_wdata = colour;
`endif

    shadow_ram_1r1w #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W),
        .DW    (COLOUR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (addr_q),
        .rdata (ram_rdata)
    );

    // Read FSM next state; RAM is read with addr_q during READ
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        oob_d        = oob_q;
        rd_ack_d     = 1'b0;
        rd_oob_d     = 1'b0;
        fwd_hit_d    = fwd_hit_q;
        fwd_colour_d = fwd_colour_q;
`ifdef PIXEL_SHADOW_CLEAR_EN
        sweep_d      = sweep_q;
`endif
        case (state_q)
`ifdef PIXEL_SHADOW_CLEAR_EN
            ST_CLEAR: begin
                sweep_d = sweep_q + ADDR_W'(1);
                if (sweep_q == ADDR_W'(DEPTH - 1)) begin
                    sweep_d = '0;
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (rd_req) begin
                    state_d = ST_READ;
                    addr_d  = xy_to_addr(rd_x, rd_y);
                    oob_d   = !((rd_x < 8'(WIDTH)) && (rd_y < 7'(HEIGHT)));
                end
            end
            ST_READ: begin
                state_d      = ST_RESP;
                rd_ack_d     = 1'b1;
                rd_oob_d     = oob_q;
                // A write landing on the same edge as the RAM read wins
                fwd_hit_d    = wr_en_c && (wr_addr_c == addr_q);
                fwd_colour_d = colour;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef PIXEL_SHADOW_CLEAR_EN
        busy_d = (state_d == ST_CLEAR);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RESET;
            addr_q       <= '0;
            oob_q        <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_oob_q     <= 1'b0;
            fwd_hit_q    <= 1'b0;
            fwd_colour_q <= '0;
`ifdef PIXEL_SHADOW_CLEAR_EN
            sweep_q      <= '0;
            busy_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            oob_q        <= oob_d;
            rd_ack_q     <= rd_ack_d;
            rd_oob_q     <= rd_oob_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_colour_q <= fwd_colour_d;
`ifdef PIXEL_SHADOW_CLEAR_EN
            sweep_q      <= sweep_d;
            busy_q       <= busy_d;
`endif
        end
    end

    // Colour is a pure mux of flops, forced to 0 outside RESP and for oob reads
    assign rd_colour = (rd_ack_q && !rd_oob_q) ? (fwd_hit_q ? fwd_colour_q : ram_rdata) : '0;
    assign rd_ack    = rd_ack_q;
    assign rd_oob    = rd_oob_q;
    assign busy      = busy_int;

endmodule

// File: tb/tb_pixel_shadow_reader.sv
// tb_pixel_shadow_reader: directed stimulus for pixel_shadow_reader, a per-cycle
// comparison against a framebuffer/handshake model, plus literal expectations.
module tb_pixel_shadow_reader;

`ifdef PIXEL_SHADOW_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    localparam int NPIX = 160 * 120;

    logic       clk = 1'b0;
    logic       reset;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       rd_req;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic       rd_ack;
    logic [2:0] rd_colour;
    logic       rd_oob;
    logic       busy;

    int errors = 0;
    int checks = 0;

    pixel_shadow_reader dut (
        .clk       (clk),
        .reset     (reset),
        .plot      (plot),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .rd_req    (rd_req),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_ack    (rd_ack),
        .rd_colour (rd_colour),
        .rd_oob    (rd_oob),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain pixel array, a countdown of clear cycles and a 3-cycle read slot
    logic [2:0] mem [NPIX];
    bit  m_on = 1'b0;
    int  busy_left = 0;
    int  cool = 0;
    bit  ack_next = 1'b0;
    bit  m_oob = 1'b0;
    int  m_addr = 0;
    bit  exp_ack = 1'b0;
    bit  exp_oob = 1'b0;
    int  exp_col = 0;
    bit  exp_busy = 1'b0;

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 3'd0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_on      = 1'b1;
            busy_left = CLEAR_EN ? NPIX : 0;
            cool      = 0;
            ack_next  = 1'b0;
            exp_ack   = 1'b0;
            exp_oob   = 1'b0;
            exp_col   = 0;
            if (CLEAR_EN) begin
                for (int i = 0; i < NPIX; i++) mem[i] = 3'd0;
            end
        end else begin
            if (plot && busy_left == 0 && x < 160 && y < 120)
                mem[int'(y) * 160 + int'(x)] = colour;
            exp_ack = 1'b0;
            exp_oob = 1'b0;
            exp_col = 0;
            if (ack_next) begin
                exp_ack  = 1'b1;
                exp_oob  = m_oob;
                exp_col  = m_oob ? 0 : int'(mem[m_addr]);
                ack_next = 1'b0;
            end
            if (cool > 0) begin
                cool--;
            end else if (busy_left == 0 && rd_req) begin
                cool     = 2;
                ack_next = 1'b1;
                m_oob    = (rd_x >= 160) || (rd_y >= 120);
                m_addr   = m_oob ? 0 : int'(rd_y) * 160 + int'(rd_x);
            end
            if (busy_left > 0) busy_left--;
        end
        exp_busy = (busy_left > 0);
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("cmp_busy", int'(busy), int'(exp_busy));
            check("cmp_ack", int'(rd_ack), int'(exp_ack));
            if (exp_ack) begin
                check("cmp_colour", int'(rd_colour), exp_col);
                check("cmp_oob", int'(rd_oob), int'(exp_oob));
            end
        end
    end

    task automatic plot_px(input int px, input int py, input int pc);
        @(posedge clk); #1;
        plot = 1'b1; x = 8'(px); y = 7'(py); colour = 3'(pc);
        @(posedge clk); #1;
        plot = 1'b0;
    endtask

    // Issue one read, return results and the cycle (1 = accept cycle) rd_ack appeared
    task automatic read_px(input int px, input int py, output int col, output int oob, output int ack_cyc);
        int n;
        n = 0;
        col = -1; oob = -1; ack_cyc = -1;
        @(posedge clk); #1;
        rd_req = 1'b1; rd_x = 8'(px); rd_y = 7'(py);
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (rd_ack) begin
                col = int'(rd_colour); oob = int'(rd_oob); ack_cyc = n;
                break;
            end
        end
        if (ack_cyc < 0) check("read_timeout", 0, 1);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < NPIX + 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 0, 1);
    endtask

    int col, oob, lat, n;
    logic [11:0] hist;

    initial begin
        reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
        rd_req = 1'b0; rd_x = '0; rd_y = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values and clear-sweep length
        @(negedge clk);
        check("rst_ack", int'(rd_ack), 0);
        check("rst_oob", int'(rd_oob), 0);
        check("rst_colour", int'(rd_colour), 0);
        check("rst_busy", int'(busy), CLEAR_EN ? 1 : 0);
        n = 0;
        while (busy && n < NPIX + 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, CLEAR_EN ? 19200 : 0);

        read_px(159, 119, col, oob, lat);
        check("corner_colour", col, 0);
        check("corner_oob", oob, 0);
        check("corner_latency", lat, 3);

        plot_px(5, 3, 7);
        read_px(5, 3, col, oob, lat);
        check("p53_colour", col, 7);
        read_px(6, 3, col, oob, lat);
        check("p63_colour", col, 0);

        // Write to the address being read, landing in the READ cycle
        plot_px(10, 10, 7);
        @(posedge clk); #1;
        rd_req = 1'b1; rd_x = 8'd10; rd_y = 7'd10;
        @(posedge clk); #1;
        plot = 1'b1; x = 8'd10; y = 7'd10; colour = 3'b010;
        @(posedge clk); #1;
        plot = 1'b0;
        @(negedge clk);
        check("fwd_ack", int'(rd_ack), 1);
        check("fwd_colour", int'(rd_colour), 2);
        @(posedge clk); #1;
        rd_req = 1'b0;
        read_px(10, 10, col, oob, lat);
        check("fwd_stored", col, 2);

        // Out-of-range reads and a dropped out-of-range write
        read_px(160, 0, col, oob, lat);
        check("oobx_oob", oob, 1);
        check("oobx_colour", col, 0);
        read_px(0, 120, col, oob, lat);
        check("ooby_oob", oob, 1);
        check("ooby_colour", col, 0);
        plot_px(200, 50, 7);
        read_px(40, 51, col, oob, lat);
        check("alias_colour", col, 0);
        check("alias_oob", oob, 0);

        // Continuous request: one ack every third cycle, one cycle wide
        @(posedge clk); #1;
        rd_req = 1'b1; rd_x = 8'd5; rd_y = 7'd3;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            hist[i] = rd_ack;
        end
        @(posedge clk); #1;
        rd_req = 1'b0;
        check("held_pattern", int'(hist), int'(12'b1001_0010_0100));
        repeat (3) @(posedge clk);

        // Reset while in READ abandons the read
        @(posedge clk); #1;
        rd_req = 1'b1; rd_x = 8'd5; rd_y = 7'd3;
        @(posedge clk); #1;
        reset = 1'b1; rd_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstrd_ack", int'(rd_ack), 0);
        check("rstrd_busy", int'(busy), CLEAR_EN ? 1 : 0);
        repeat (3) @(negedge clk);
        wait_idle();
        read_px(5, 3, col, oob, lat);
        check("after_rst_colour", col, CLEAR_EN ? 0 : 7);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
